// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI-to-SRAM burst slave.
// Provides the controller state encoding, the default burst geometry
// (a 256-bit cache line moved as four 64-bit beats) and the AXI widths
// that match the core's master port.
package axi_sram_pkg;

  localparam int AXI_DATA_W  = 64;
  localparam int AXI_ADDR_W  = 32;
  localparam int BURST_LEN   = 4;
  localparam int BURST_CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_RD_HOLD,
    ST_WR_DATA
  } state_e;

endpackage

// File: rtl/axi_sram_slave.sv
// Memory-side slave for the core's simplified AXI port (AR/R and AW/W only,
// fixed-length bursts, no id/len/last/B). Each burst is serialised onto a
// single-port synchronous SRAM with one cycle of read latency.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ar_addr/valid/ready        read burst start byte address handshake
//   r_valid/ready, r_data      read beats
//   aw_addr/valid/ready        write burst start byte address handshake
//   w_data/valid/ready         write beats
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   SRAM port
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int DATA_W      = AXI_DATA_W,
  parameter int ADDR_W      = AXI_ADDR_W,
  parameter int MEM_AW      = 16,
  parameter int BURST_BEATS = BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int WORD_W = ADDR_W - 3;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte offsets within a word are ignored; this keeps them visibly consumed.
  logic unused_ofs;
  assign unused_ofs = ^{ar_addr[2:0], aw_addr[2:0]};

  // The SRAM index is the low MEM_AW bits of the word address, so a burst
  // running past the top of the array wraps to word 0.
  assign mem_addr  = MEM_AW'(base_q + WORD_W'(beat_q));
  assign mem_wdata = w_data;
  assign r_data    = rdata_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    rdata_d  = rdata_q;
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    r_valid  = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;

    // All handshake and SRAM strobes are forced low while reset is held.
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          aw_ready = 1'b1;
          // Writes win a tie so a dirty writeback lands before its refill.
          ar_ready = !aw_valid;
          if (aw_valid) begin
            base_d  = aw_addr[ADDR_W-1:3];
            beat_d  = '0;
            state_d = ST_WR_DATA;
          end else if (ar_valid) begin
            base_d  = ar_addr[ADDR_W-1:3];
            beat_d  = '0;
            state_d = ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          mem_en  = 1'b1;
          state_d = ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          // SRAM data is valid one cycle after the issue.
          rdata_d = mem_rdata;
          state_d = ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          r_valid = 1'b1;
          if (r_ready) begin
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = ST_IDLE;
            end else begin
              beat_d  = beat_q + 1'b1;
              state_d = ST_RD_ISSUE;
            end
          end
        end
        ST_WR_DATA: begin
          w_ready = 1'b1;
          mem_en  = w_valid;
          mem_we  = w_valid;
          if (w_valid) begin
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = ST_IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int MEM_AW = 16;
  localparam int BEATS  = 4;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic              ar_valid, ar_ready, aw_valid, aw_ready;
  logic              r_valid, r_ready, w_valid, w_ready;
  logic [DATA_W-1:0] r_data, w_data;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  axi_sram_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BURST_BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents of any SRAM word that has never been written.
  function automatic logic [63:0] init_pattern(input int a);
    return {16'hC0DE, a[15:0], a * 32'h9E3779B1};
  endfunction

  // ---------------- SRAM model: synchronous, 1-cycle read ----------------
  logic [63:0] sram [DEPTH];
  bit          written [DEPTH];
  logic        pre_we = 1'b0;
  logic [MEM_AW-1:0] pre_addr = '0;
  logic [63:0] pre_data = '0;

  function automatic logic [63:0] sram_word(input int a);
    return written[a] ? sram[a] : init_pattern(a);
  endfunction

  always @(posedge clk) begin
    if (pre_we) begin
      sram[pre_addr]    <= pre_data;
      written[pre_addr] <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr]    <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= sram_word(int'(mem_addr));
      end
    end
  end

  // ---------------- Reference model and scoreboards ----------------
  logic [63:0] ref_mem [int];
  logic [63:0] exp_q [$];
  int          waddr_q [$];
  logic [63:0] wdata_q [$];

  function automatic logic [63:0] ref_word(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pattern(a);
  endfunction

  function automatic int word_of(input logic [31:0] addr, input int b);
    return (int'(addr >> 3) + b) & (DEPTH - 1);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got beat %h expected none", r_data);
        end else begin
          check_eq("r_data", r_data, exp_q.pop_front());
        end
      end
      if (r_valid) check_eq("mem_en_idle_in_hold", mem_en, 1'b0);
      if (mem_en && mem_we) begin
        if (waddr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got write addr %h expected none", mem_addr);
        end else begin
          check_eq("w_addr", mem_addr, waddr_q.pop_front());
          check_eq("w_data", mem_wdata, wdata_q.pop_front());
        end
      end
    end
  end

  // ---------------- Stimulus tasks (enter and leave at posedge+1) --------
  task automatic preload(input int a, input logic [63:0] d);
    pre_addr = MEM_AW'(a); pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // stall_beat: beat held off for stall_len cycles; abort_beat: beat during
  // whose hold phase reset is pulsed (BEATS = none for either).
  task automatic do_read(input logic [31:0] addr, input int stall_beat, input int stall_len,
                         input int abort_beat);
    int n, hs;
    logic [63:0] held;
    for (int b = 0; b < BEATS && b < abort_beat; b++) exp_q.push_back(ref_word(word_of(addr, b)));
    ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!ar_ready) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got ar_ready 0 expected 1");
      ar_valid = 1'b0; @(posedge clk); #1;
      return;
    end
    hs = cyc;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      r_ready = (b != stall_beat) && (b != abort_beat);
      n = 0;
      @(negedge clk);
      while (!r_valid && n < 20) begin @(negedge clk); n++; end
      if (!r_valid) begin
        checks++; errors++;
        $display("FAIL r_timeout: got r_valid 0 expected 1 (beat %0d)", b);
        r_ready = 1'b1; @(posedge clk); #1;
        return;
      end
      check_eq("r_latency", cyc - hs, 3);
      if (b == abort_beat) begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_r_valid", r_valid, 1'b0);
        check_eq("rst_ar_ready", ar_ready, 1'b0);
        check_eq("rst_aw_ready", aw_ready, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_r_data", r_data, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; r_ready = 1'b1;
        @(negedge clk);
        check_eq("ar_ready_after_rst", ar_ready, 1'b1);
        @(posedge clk); #1;
        return;
      end
      if (b == stall_beat) begin
        held = r_data;
        for (int k = 0; k < stall_len; k++) begin
          check_eq("stall_r_valid", r_valid, 1'b1);
          check_eq("stall_r_data", r_data, held);
          @(negedge clk);
        end
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(negedge clk);
      end
      hs = cyc;
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    @(negedge clk);
    check_eq("ar_ready_after_burst", ar_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] d [BEATS],
                          input int gap_after, input int gap_len,
                          input bit chk_ar, input bit idle_chk);
    int b, gap, n, wa;
    bit aw_hs, w_hs;
    for (int i = 0; i < BEATS; i++) begin
      wa = word_of(addr, i);
      waddr_q.push_back(wa); wdata_q.push_back(d[i]);
      ref_mem[wa] = d[i];
    end
    aw_addr = addr; aw_valid = 1'b1;
    b = 0; gap = 0; n = 0;
    // W is offered together with AW; it must wait until the address is taken.
    while (b < BEATS && n < 100) begin
      w_valid = (gap == 0); w_data = d[b];
      @(negedge clk);
      if (chk_ar) check_eq("ar_blocked_by_write", ar_ready, 1'b0);
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      @(posedge clk); #1;
      n++;
      if (aw_hs) aw_valid = 1'b0;
      if (w_hs) begin
        if (b == gap_after) gap = gap_len;
        b++;
      end else if (gap > 0) gap--;
    end
    w_valid = 1'b0; aw_valid = 1'b0;
    if (b < BEATS) begin
      checks++; errors++;
      $display("FAIL w_timeout: got %0d beats expected %0d", b, BEATS);
    end
    if (idle_chk) begin
      @(negedge clk);
      check_eq("aw_ready_after_burst", aw_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    logic [63:0] wd [BEATS];
    logic [31:0] a;
    rst = 1'b1;
    ar_addr = '0; ar_valid = 1'b0; aw_addr = '0; aw_valid = 1'b0;
    w_data = '0; w_valid = 1'b0; r_ready = 1'b1;

    @(negedge clk);
    check_eq("reset_ar_ready", ar_ready, 1'b0);
    check_eq("reset_aw_ready", aw_ready, 1'b0);
    check_eq("reset_w_ready", w_ready, 1'b0);
    check_eq("reset_r_valid", r_valid, 1'b0);
    check_eq("reset_mem_en", mem_en, 1'b0);
    check_eq("reset_mem_we", mem_we, 1'b0);
    check_eq("reset_r_data", r_data, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ar_ready", ar_ready, 1'b1);
    check_eq("idle_aw_ready", aw_ready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < BEATS; i++) preload(32'h100 + i, 64'hA0 + 64'(i));

    // Plain line refill, then the same line with beat 1 stalled.
    do_read(32'h800, BEATS, 0, BEATS);
    do_read(32'h800, 1, 5, BEATS);

    // Writeback with a gap after beat 1.
    wd = '{64'h11, 64'h22, 64'h33, 64'h44};
    do_write(32'h1000, wd, 1, 2, 1'b0, 1'b1);
    for (int i = 0; i < BEATS; i++) check_eq("sram_after_write", sram_word(32'h200 + i), wd[i]);

    // Simultaneous AW and AR to the same line: write first, then the read sees it.
    wd = '{64'hD1, 64'hD2, 64'hD3, 64'hD4};
    ar_addr = 32'h800; ar_valid = 1'b1;
    do_write(32'h800, wd, BEATS, 0, 1'b1, 1'b0);
    do_read(32'h800, BEATS, 0, BEATS);

    // Unaligned start and wrap past the top of the array.
    do_read(32'h7C, BEATS, 0, BEATS);
    do_read(32'h7FFFC, 2, 2, BEATS);

    // Reset while beat 2 is held, then a fresh burst.
    do_read(32'h1000, BEATS, 0, 2);
    do_read(32'h1000, BEATS, 0, BEATS);

    // Randomised mix of reads and writes.
    for (int it = 0; it < 10; it++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, $urandom_range(0, BEATS), $urandom_range(1, 4), BEATS);
      end else begin
        for (int i = 0; i < BEATS; i++) wd[i] = {$urandom, $urandom};
        do_write(a, wd, $urandom_range(0, BEATS - 1), $urandom_range(0, 3), 1'b0, 1'b1);
        do_read(a, BEATS, 0, BEATS);
      end
    end

    repeat (3) @(negedge clk);
    check_eq("read_queue_drained", exp_q.size(), 0);
    check_eq("write_queue_drained", waddr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
